// File: rtl/lsu.sv
// ----------------------------------------------------------------------------
// lsu : load/store unit for the MEM stage of a 32-bit in-order pipeline.
//
// Loads and word stores complete in the cycle they are presented. Byte and
// halfword stores are done as read-modify-write: the containing word is read
// in IDLE (one stall cycle), then the merged word is written in MERGE.
// Illegal requests are rejected without touching memory. They produce a
// one-cycle err pulse on the following cycle, and err_addr latches the
// offending address.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/re/we         MEM-stage request, load and store qualifiers
//   funct3                  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   addr, wdata             byte address, right-aligned store data
//   load_data               extracted and extended load result
//   stall                   freeze the upstream pipeline this cycle
//   err, err_addr           illegal-request pulse and its address
//   dm_memread/dm_memwrite  data-memory enables (never both at once)
//   dm_addr, dm_wd, dm_rd   word address, write data, combinational read data
// ----------------------------------------------------------------------------
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_re,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        err,
    output logic [31:0] err_addr,
    output logic        dm_memread,
    output logic        dm_memwrite,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    input  logic [31:0] dm_rd
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_e;

    state_e      state_q, state_d;

    // Read-modify-write capture registers. Only the size bits of funct3 and
    // the low half of wdata are needed to build the merged word.
    logic [31:0] word_q;
    logic [29:0] waddr_q;
    logic [15:0] wdata_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;

    logic        err_q;
    logic [31:0] err_addr_q;

    logic        f3_ok_s;
    logic        misalign_s;
    logic        illegal_s;
    logic        legal_load_s;
    logic        legal_store_s;
    logic        word_store_s;
    logic        sub_store_s;

    // Select the addressed lane of a word and sign- or zero-extend it.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        if (off[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Replace the target byte or halfword of the old word with store data.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [15:0] wd,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: begin
                case (off)
                    2'b00:   r[7:0]   = wd[7:0];
                    2'b01:   r[15:8]  = wd[7:0];
                    2'b10:   r[23:16] = wd[7:0];
                    2'b11:   r[31:24] = wd[7:0];
                    default: r = word;
                endcase
            end
            2'b01: begin
                if (off[1]) begin
                    r[31:16] = wd;
                end else begin
                    r[15:0] = wd;
                end
            end
            default: r = word;
        endcase
        return r;
    endfunction

    // Request legality and classification (only meaningful in IDLE).
    always_comb begin
        f3_ok_s    = 1'b0;
        misalign_s = 1'b0;
        illegal_s  = 1'b0;
        case (funct3)
            3'b000:  f3_ok_s = 1'b1;
            3'b001:  f3_ok_s = 1'b1;
            3'b010:  f3_ok_s = 1'b1;
            3'b100:  f3_ok_s = req_re;   // unsigned variants exist for loads only
            3'b101:  f3_ok_s = req_re;
            default: f3_ok_s = 1'b0;
        endcase
        case (funct3[1:0])
            2'b01:   misalign_s = addr[0];
            2'b10:   misalign_s = |addr[1:0];
            default: misalign_s = 1'b0;
        endcase
        if ((state_q == ST_IDLE) && req_valid) begin
            if (req_re && req_we) begin
                illegal_s = 1'b1;
            end else if (req_re || req_we) begin
                illegal_s = ~f3_ok_s | misalign_s;
            end else begin
                illegal_s = 1'b0;
            end
        end else begin
            illegal_s = 1'b0;
        end
    end

    assign legal_load_s  = (state_q == ST_IDLE) & req_valid & req_re & ~req_we & ~illegal_s;
    assign legal_store_s = (state_q == ST_IDLE) & req_valid & req_we & ~req_re & ~illegal_s;
    assign word_store_s  = legal_store_s & (funct3 == 3'b010);
    assign sub_store_s   = legal_store_s & (funct3 != 3'b010);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sub_store_s) begin
                    state_d = ST_MERGE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MERGE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; everything is held quiet while reset is asserted.
    always_comb begin
        load_data   = 32'h0000_0000;
        stall       = 1'b0;
        dm_memread  = 1'b0;
        dm_memwrite = 1'b0;
        dm_addr     = {addr[31:2], 2'b00};
        dm_wd       = 32'h0000_0000;
        if (!rst_n) begin
            dm_wd = 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (legal_load_s) begin
                        dm_memread = 1'b1;
                        load_data  = extract_load(dm_rd, funct3, addr[1:0]);
                    end else if (word_store_s) begin
                        dm_memwrite = 1'b1;
                        dm_wd       = wdata;
                    end else if (sub_store_s) begin
                        dm_memread = 1'b1;
                        stall      = 1'b1;
                    end else begin
                        dm_memread = 1'b0;
                    end
                end
                ST_MERGE: begin
                    dm_memwrite = 1'b1;
                    dm_addr     = {waddr_q, 2'b00};
                    dm_wd       = merge_store(word_q, wdata_q, size_q, off_q);
                end
                default: begin
                    dm_memwrite = 1'b0;
                end
            endcase
        end
    end

    // Capture the old word and store parameters for the MERGE write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= 32'h0000_0000;
            waddr_q <= 30'h0000_0000;
            wdata_q <= 16'h0000;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
        end else if (sub_store_s) begin
            word_q  <= dm_rd;
            waddr_q <= addr[31:2];
            wdata_q <= wdata[15:0];
            size_q  <= funct3[1:0];
            off_q   <= addr[1:0];
        end else begin
            word_q  <= word_q;
            waddr_q <= waddr_q;
            wdata_q <= wdata_q;
            size_q  <= size_q;
            off_q   <= off_q;
        end
    end

    // Error pulse and sticky error address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            err_addr_q <= 32'h0000_0000;
        end else begin
            err_q <= illegal_s;
            if (illegal_s) begin
                err_addr_q <= addr;
            end else begin
                err_addr_q <= err_addr_q;
            end
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_re;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] load_data;
    logic        stall;
    logic        err;
    logic [31:0] err_addr;
    logic        dm_memread;
    logic        dm_memwrite;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_rd;

    int n_checks = 0;
    int n_fail   = 0;

    // Data memory: 64 words, indexed by dm_addr[7:2].
    logic [31:0] mem [0:63];
    logic [7:0]  rb  [0:255];       // reference byte-addressed memory
    logic [31:0] exp_err_addr = 32'h0;

    lsu dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_re(req_re),
        .req_we(req_we), .funct3(funct3), .addr(addr), .wdata(wdata),
        .load_data(load_data), .stall(stall), .err(err), .err_addr(err_addr),
        .dm_memread(dm_memread), .dm_memwrite(dm_memwrite), .dm_addr(dm_addr),
        .dm_wd(dm_wd), .dm_rd(dm_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_rd = mem[dm_addr[7:2]];

    always @(posedge clk) begin
        if (dm_memwrite) mem[dm_addr[7:2]] <= dm_wd;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic re, input logic we,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_valid = v; req_re = re; req_we = we; funct3 = f3; addr = a; wdata = wd;
    endtask

    // ---------------- reference model (byte-level arithmetic) ----------------
    function automatic int access_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic model_illegal(input logic re, input logic we,
                                           input logic [2:0] f3, input logic [31:0] a);
        if (re && we) return 1'b1;
        if (!re && !we) return 1'b0;
        if (re && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (we && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
        return (a % access_bytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int base;
        base = int'(a[7:0]) & 252;
        return {rb[base+3], rb[base+2], rb[base+1], rb[base]};
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        longint v;
        int n;
        int base;
        n = access_bytes(f3);
        base = int'(a[7:0]);
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(rb[base+i]) << (8 * i));
        if (f3[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int base;
        base = int'(a[7:0]);
        for (int i = 0; i < access_bytes(f3); i++) rb[base+i] = wd[8*i +: 8];
    endtask

    // One request through the DUT, checked against the model. Starts and
    // ends 1 time unit after a rising edge.
    task automatic do_op(input logic v, input logic re, input logic we,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic ill, is_ld, is_st, sub;
        logic [31:0] exp_ld, exp_wd;
        ill    = v && model_illegal(re, we, f3, a);
        is_ld  = v && re && !we && !ill;
        is_st  = v && we && !re && !ill;
        sub    = is_st && (access_bytes(f3) < 4);
        exp_ld = is_ld ? model_load(f3, a) : 32'h0;
        exp_wd = (is_st && !sub) ? wd : 32'h0;
        if (is_st) model_store(f3, a, wd);
        drive(v, re, we, f3, a, wd);
        @(negedge clk);
        chk("op_load_data", load_data, exp_ld);
        chk("op_stall", {31'h0, stall}, {31'h0, sub});
        chk("op_memread", {31'h0, dm_memread}, {31'h0, is_ld || sub});
        chk("op_memwrite", {31'h0, dm_memwrite}, {31'h0, is_st && !sub});
        chk("op_dm_wd", dm_wd, exp_wd);
        if (v) chk("op_dm_addr", dm_addr, {a[31:2], 2'b00});
        @(posedge clk); #1;
        if (ill) exp_err_addr = a;
        chk("op_err", {31'h0, err}, {31'h0, ill});
        chk("op_err_addr", err_addr, exp_err_addr);
        if (sub) begin
            // Arbitrary request inputs during MERGE must be ignored.
            drive(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom);
            @(negedge clk);
            chk("merge_memwrite", {31'h0, dm_memwrite}, 32'h1);
            chk("merge_memread", {31'h0, dm_memread}, 32'h0);
            chk("merge_stall", {31'h0, stall}, 32'h0);
            chk("merge_dm_addr", dm_addr, {a[31:2], 2'b00});
            chk("merge_dm_wd", dm_wd, model_word(a));
            chk("merge_load_data", load_data, 32'h0);
            @(posedge clk); #1;
            chk("merge_err", {31'h0, err}, 32'h0);
        end
    endtask

    typedef struct {
        logic        re;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] exp_ld;
        logic        exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 3'b000, 32'h7,  32'h0000_0011, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 3'b001, 32'h4,  32'h0000_3344, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 3'b000, 32'h8,  32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 3'b100, 32'h8,  32'h0000_00FF, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 3'b001, 32'hA,  32'h0000_0000, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 3'b010, 32'h6,  32'h0000_0000, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 3'b001, 32'h3,  32'h0000_0000, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 3'b000, 32'h20, 32'h0000_0000, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 3'b010, 32'h4,  32'h1122_3344, 1'b1, 1'b0};

        // Reset with a live load request: everything must stay quiet.
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h4, 32'hFFFF_FFFF);
        #3;
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_memread", {31'h0, dm_memread}, 32'h0);
        chk("rst_memwrite", {31'h0, dm_memwrite}, 32'h0);
        chk("rst_dm_wd", dm_wd, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Preload words with SW.
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0, 32'hAABB_CCDD);
        @(negedge clk);
        chk("sw_memwrite", {31'h0, dm_memwrite}, 32'h1);
        chk("sw_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h4, 32'h1122_3344);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h8, 32'h0000_80FF);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'hC, 32'h0102_0304);
        @(posedge clk); #1;

        // Table-driven loads and illegal requests.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, vecs[i].re, vecs[i].we, vecs[i].f3, vecs[i].a, 32'h0);
            @(negedge clk);
            chk($sformatf("vec%0d_load_data", i), load_data, vecs[i].exp_ld);
            chk($sformatf("vec%0d_stall", i), {31'h0, stall}, 32'h0);
            chk($sformatf("vec%0d_memread", i), {31'h0, dm_memread}, {31'h0, vecs[i].exp_rd});
            chk($sformatf("vec%0d_memwrite", i), {31'h0, dm_memwrite}, 32'h0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
            if (vecs[i].exp_err) chk($sformatf("vec%0d_err_addr", i), err_addr, vecs[i].a);
        end

        // SB then SH read-modify-write on word 0, with illegal junk in MERGE.
        drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h1, 32'h0000_0055);
        @(negedge clk);
        chk("sb_stall", {31'h0, stall}, 32'h1);
        chk("sb_memread", {31'h0, dm_memread}, 32'h1);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 3'b111, 32'h3, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("sb_merge_memwrite", {31'h0, dm_memwrite}, 32'h1);
        chk("sb_merge_stall", {31'h0, stall}, 32'h0);
        chk("sb_merge_dm_addr", dm_addr, 32'h0);
        chk("sb_merge_dm_wd", dm_wd, 32'hAABB_55DD);
        @(posedge clk); #1;
        chk("sb_merge_no_err", {31'h0, err}, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h2, 32'h0000_1234);
        @(negedge clk);
        chk("sh_stall", {31'h0, stall}, 32'h1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        chk("sh_merge_dm_wd", dm_wd, 32'h1234_55DD);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        @(negedge clk);
        chk("sh_readback", load_data, 32'h1234_55DD);
        @(posedge clk); #1;

        // Reset while in MERGE: pending write is dropped.
        drive(1'b1, 1'b0, 1'b1, 3'b000, 32'hC, 32'h0000_00AA);
        @(negedge clk);
        chk("rstm_stall", {31'h0, stall}, 32'h1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rstm_memwrite", {31'h0, dm_memwrite}, 32'h0);
        chk("rstm_stall_off", {31'h0, stall}, 32'h0);
        chk("rstm_err_addr", err_addr, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'hC, 32'h0);
        @(negedge clk);
        chk("rstm_readback", load_data, 32'h0102_0304);
        chk("rstm_readback_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;

        // SW followed immediately by LW of the same word.
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("swlw_memwrite", {31'h0, dm_memwrite}, 32'h1);
        chk("swlw_sw_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        chk("swlw_load_data", load_data, 32'hDEAD_BEEF);
        chk("swlw_lw_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        exp_err_addr = 32'h0;   // last reset cleared err_addr, no illegal since

        // Randomized phase: preload every word, then mixed traffic.
        for (int w = 0; w < 64; w++)
            do_op(1'b1, 1'b0, 1'b1, 3'b010, {($urandom & 32'hFFFF_FF00) | 32'(w * 4)}, $urandom);
        for (int n = 0; n < 500; n++) begin
            logic v, re, we;
            v  = ($urandom_range(0, 7) != 0);
            re = 1'($urandom);
            we = ($urandom_range(0, 5) == 0) ? re : ~re;
            do_op(v, re, we, 3'($urandom),
                  {$urandom & 32'hFFFF_FF00} | 32'($urandom_range(0, 255)), $urandom);
        end
        for (int w = 0; w < 64; w++)
            do_op(1'b1, 1'b1, 1'b0, 3'b010, 32'(w * 4), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
